// File: rtl/regfile_rename.sv
// rtl/regfile_rename.sv - architectural register file with ROB-tag rename table, commit bypass and flush
module regfile_rename #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int TAG_W = 4,
    localparam int RW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iss_en,
    input  logic [RW-1:0]    iss_rs1,
    input  logic [RW-1:0]    iss_rs2,
    input  logic [RW-1:0]    iss_rd,
    input  logic [TAG_W-1:0] iss_tag,
    output logic             rd_valid,
    output logic [XLEN-1:0]  rs1_data,
    output logic             rs1_busy,
    output logic [TAG_W-1:0] rs1_tag,
    output logic [XLEN-1:0]  rs2_data,
    output logic             rs2_busy,
    output logic [TAG_W-1:0] rs2_tag,
    input  logic             cm_en,
    input  logic [RW-1:0]    cm_idx,
    input  logic [TAG_W-1:0] cm_tag,
    input  logic [XLEN-1:0]  cm_data,
    input  logic             flush
);

    typedef struct packed {
        logic             busy;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
    } opnd_t;

    logic [XLEN-1:0]  mem [NREG];
    logic [NREG-1:0]  busy;
    logic [TAG_W-1:0] tag [NREG];

    logic [RW-1:0] s1_i, s2_i, rd_i, cm_i;
    logic          iss_ok, cm_hit;
    opnd_t         op1, op2;

    // Indices beyond the implemented range alias register 0.
    function automatic logic [RW-1:0] eff(input logic [RW-1:0] i);
        return ({1'b0, i} < (RW+1)'(NREG)) ? i : '0;
    endfunction

    function automatic opnd_t lookup(input logic [RW-1:0] i);
        opnd_t o;
        o = '0;
        if (i != '0) begin
            o.data = mem[i];
            if (busy[i]) begin
                if (cm_en && cm_i == i && tag[i] == cm_tag) begin
                    o.data = cm_data;
                end else begin
                    o.busy = 1'b1;
                    o.tag  = tag[i];
                end
            end
        end
        return o;
    endfunction

    always_comb begin
        s1_i   = eff(iss_rs1);
        s2_i   = eff(iss_rs2);
        rd_i   = eff(iss_rd);
        cm_i   = eff(cm_idx);
        iss_ok = iss_en && !flush;
        cm_hit = cm_en && (cm_i != '0);
        op1    = lookup(s1_i);
        op2    = lookup(s2_i);
    end

    // Order matters: issue overrides commit's busy clear, flush overrides both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
                tag[i] <= '0;
            end
        end else begin
            if (cm_hit) begin
                mem[cm_i] <= cm_data;
                if (busy[cm_i] && tag[cm_i] == cm_tag) begin
                    busy[cm_i] <= 1'b0;
                end
            end
            if (iss_ok && rd_i != '0) begin
                busy[rd_i] <= 1'b1;
                tag[rd_i]  <= iss_tag;
            end
            if (flush) begin
                busy <= '0;
                for (int i = 0; i < NREG; i++) begin
                    tag[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rs1_data <= '0;
            rs1_busy <= 1'b0;
            rs1_tag  <= '0;
            rs2_data <= '0;
            rs2_busy <= 1'b0;
            rs2_tag  <= '0;
        end else begin
            rd_valid <= iss_ok;
            if (iss_ok) begin
                rs1_data <= op1.data;
                rs1_busy <= op1.busy;
                rs1_tag  <= op1.tag;
                rs2_data <= op2.data;
                rs2_busy <= op2.busy;
                rs2_tag  <= op2.tag;
            end
        end
    end

endmodule
